// File: rtl/run_gen_pkg.sv
// Shared types and defaults for the serial run generator.
// Build with +define+RUN_MARK_EN to enable the streak/mark monitor.
package run_gen_pkg;

  localparam int LEN_W_DEF      = 4;
  localparam int RUN_THRESH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                 level;
    logic [LEN_W_DEF-1:0] len;
  } run_desc_t;

endpackage

// File: rtl/run_streak_mon.sv
// Streak counter over the emitted bit stream; raises mark once a
// streak of equal valid bits reaches RUN_THRESH (RUN_MARK_EN builds).
import run_gen_pkg::*;

module run_streak_mon #(
  parameter int RUN_THRESH = RUN_THRESH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_i,
  input  logic valid_i,
  output logic mark_o
);

  localparam int SW = $clog2(RUN_THRESH + 1);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          last_q;
  logic          mark_q;

  // Next streak for the bit about to appear on the line.
  always_comb begin
    streak_d = SW'(1);
    if (streak_q != '0 && bit_i == last_q) begin
      if (streak_q >= SW'(RUN_THRESH))
        streak_d = streak_q;
      else
        streak_d = streak_q + SW'(1);
    end
  end

  // Idle cycles hold the streak; mark is registered alongside out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak_q <= '0;
      last_q   <= 1'b0;
      mark_q   <= 1'b0;
    end else if (valid_i) begin
      streak_q <= streak_d;
      last_q   <= bit_i;
      mark_q   <= streak_d >= SW'(RUN_THRESH);
    end else begin
      mark_q   <= 1'b0;
    end
  end

  assign mark_o = mark_q;

endmodule

// File: rtl/run_stream_gen.sv
// Serial run generator: {level,len} descriptors in, one bit per clock out.
// Optional streak marking is enabled with the RUN_MARK_EN macro.
import run_gen_pkg::*;

module run_stream_gen #(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int RUN_THRESH = RUN_THRESH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_valid,
  output logic             run_ready,
  input  logic             run_level,
  input  logic [LEN_W-1:0] run_len,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             run_done,
  output logic             mark
);

  state_e           state_q;
  logic [LEN_W-1:0] count_q;
  logic             out_q;
  logic             vld_q;
  logic             busy_q;
  logic             done_q;

  logic last;
  logic accept;
  logic load;
  logic emit_d;
  logic level_d;

  assign last      = (state_q == EMIT) && (count_q == LEN_W'(1));
  assign run_ready = (state_q == IDLE) || last;
  assign accept    = run_valid && run_ready;
  assign load      = accept && (run_len != '0);
  assign emit_d    = load || ((state_q == EMIT) && !last);
  assign level_d   = load ? run_level : out_q;

  // Run FSM; out keeps the last level so the line idles there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= emit_d ? EMIT : IDLE;
      out_q   <= level_d;
      vld_q   <= emit_d;
      busy_q  <= emit_d;
      done_q  <= last || (accept && run_len == '0);
      if (load)
        count_q <= run_len;
      else if (state_q == EMIT)
        count_q <= count_q - LEN_W'(1);
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign run_done  = done_q;

`ifdef RUN_MARK_EN
  run_streak_mon #(
    .RUN_THRESH(RUN_THRESH)
  ) u_streak (
    .clk    (clk),
    .reset  (reset),
    .bit_i  (level_d),
    .valid_i(emit_d),
    .mark_o (mark)
  );
`else
  // Threshold has no effect without the streak monitor.
  assign mark = (RUN_THRESH < 0);
`endif

endmodule

// File: tb/tb_run_stream_gen.sv
// Directed plus random bench for run_stream_gen against a bit-queue model.
// Mark expectations follow RUN_MARK_EN when defined for the build.
module tb_run_stream_gen;

  localparam int LW  = 4;
  localparam int THR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run_valid;
  logic          run_ready;
  logic          run_level;
  logic [LW-1:0] run_len;
  logic          out;
  logic          out_valid;
  logic          busy;
  logic          run_done;
  logic          mark;

  run_stream_gen dut (
    .clk      (clk),
    .reset    (reset),
    .run_valid(run_valid),
    .run_ready(run_ready),
    .run_level(run_level),
    .run_len  (run_len),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .run_done (run_done),
    .mark     (mark)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic last;
  } mbit_t;

  mbit_t q[$];
  logic  m_idle;
  logic  m_done;
  logic  m_mark;
  logic  m_lastb;
  int    m_streak;

  int checks = 0;
  int errors = 0;
  int obs_done = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic ev;
    logic eo;
    logic em;
    ev = q.size() > 0;
    eo = ev ? q[0].b : m_idle;
`ifdef RUN_MARK_EN
    em = m_mark;
`else
    em = 1'b0;
`endif
    chk("out_valid", out_valid, ev);
    chk("out", out, eo);
    chk("busy", busy, ev);
    chk("run_ready", run_ready, q.size() <= 1);
    chk("run_done", run_done, m_done);
    chk("mark", mark, em);
    if (run_done === 1'b1) obs_done++;
  endtask

  task automatic model_edge(input logic r, input logic v, input logic l,
                            input logic [LW-1:0] n);
    mbit_t p;
    bit acc;
    if (!r) begin
      q.delete();
      m_idle = 1'b0;
      m_done = 1'b0;
      m_mark = 1'b0;
      m_streak = 0;
      m_lastb = 1'b0;
      return;
    end
    acc = v && (q.size() <= 1);
    m_done = 1'b0;
    if (q.size() > 0) begin
      p = q.pop_front();
      m_idle = p.b;
      if (p.last) m_done = 1'b1;
    end
    if (acc) begin
      if (n == 0) m_done = 1'b1;
      for (int i = 0; i < int'(n); i++) begin
        p.b = l;
        p.last = (i == int'(n) - 1);
        q.push_back(p);
      end
    end
    if (q.size() > 0) begin
      if (m_streak > 0 && q[0].b == m_lastb) m_streak++;
      else m_streak = 1;
      m_lastb = q[0].b;
      m_mark = m_streak >= THR;
    end else begin
      m_mark = 1'b0;
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic l,
                       input logic [LW-1:0] n);
    @(negedge clk);
    if (chk_en) check_all();
    reset = r;
    run_valid = v;
    run_level = l;
    run_len = n;
    @(posedge clk);
    model_edge(r, v, l, n);
    chk_en = 1'b1;
  endtask

  task automatic send(input logic l, input logic [LW-1:0] n);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = q.size() <= 1;
      cycle(1'b1, 1'b1, l, n);
    end
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int c);
    for (int k = 0; k < c; k++) cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    run_valid = 1'b0;
    run_level = 1'b0;
    run_len = '0;
    m_idle = 1'b0;
    m_done = 1'b0;
    m_mark = 1'b0;
    m_lastb = 1'b0;
    m_streak = 0;

    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, '0);
    idle(2);

    send(1'b1, 4'd3);
    idle(5);

    obs_done = 0;
    send(1'b1, 4'd2);
    send(1'b0, 4'd5);
    send(1'b1, 4'd1);
    idle(4);
    chk("b2b_done_pulses", obs_done, 3);

    obs_done = 0;
    send(1'b1, 4'd0);
    idle(3);
    send(1'b0, 4'd3);
    send(1'b1, 4'd0);
    idle(4);
    chk("zero_len_done_pulses", obs_done, 2);

    send(1'b0, 4'd15);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    idle(2);
    send(1'b1, 4'd2);
    idle(4);

    cycle(1'b0, 1'b0, 1'b0, '0);
    send(1'b1, 4'd2);
    send(1'b1, 4'd3);
    send(1'b0, 4'd4);
    idle(3);

    send(1'b1, 4'd15);
    idle(17);

    for (int k = 0; k < 600; k++) begin
      logic r;
      logic [LW-1:0] n;
      r = ($urandom_range(0, 99) != 0);
      n = ($urandom_range(0, 3) == 0) ? LW'($urandom) :
                                        LW'($urandom_range(0, 3));
      cycle(r, LW'($urandom_range(0, 2)) != 0, 1'($urandom), n);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
